// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array input feeder.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } systolic_feeder_state_t;

  // Cycles of zero flush needed for the last skewed word to cross the array.
  function automatic int drain_cycles(input int size);
    return 2 * (size - 1);
  endfunction

endpackage

// File: rtl/systolic_skew_lane.sv
// Enable-gated delay line for one array lane; depth 0 degenerates to a wire.
module systolic_skew_lane #(
  parameter int n     = 16,
  parameter int depth = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  if (depth == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign q = d;
  end else begin : g_shift
    logic [n-1:0] stage [depth];

    // NOTE: the delay stages sit in the operand path, so they are cleared on
    // reset; otherwise stale words would be injected into the array.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < depth; k++) stage[k] <= '0;
      end else if (en) begin
        stage[0] <= d;
        for (int k = 1; k < depth; k++) stage[k] <= stage[k-1];
      end
    end

    assign q = stage[depth-1];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Skews x/w vectors into a size x size systolic array, flushes with zeros, pulses done.
// Optional stall counter port perf_stalls when SYSTOLIC_FEEDER_PERF_EN is defined.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int n    = 16,
  parameter int size = 4,
  parameter int lw   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [lw-1:0]     len,
  input  logic [size*n-1:0] recv_x,
  input  logic [size*n-1:0] recv_w,
  input  logic              recv_val,
  output logic              recv_rdy,
  output logic [size*n-1:0] x_out,
  output logic [size*n-1:0] w_out,
  output logic              en_out,
  output logic              busy,
  output logic              done
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int              dw         = $clog2(2 * size);
  localparam logic [dw-1:0]   drain_load = dw'(drain_cycles(size));

  systolic_feeder_state_t state;
  logic [lw-1:0]          remaining;
  logic [dw-1:0]          drain_cnt;
  logic                   fire;

  // recv_rdy is registered and high exactly while in STREAM.
  assign fire   = recv_val & recv_rdy;
  assign en_out = fire | (state == DRAIN);

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see this cycle's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      recv_rdy  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            if (len != '0) begin
              state    <= STREAM;
              recv_rdy <= 1'b1;
              busy     <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (fire) begin
            remaining <= remaining - lw'(1);
            if (remaining == lw'(1)) begin
              state     <= DRAIN;
              recv_rdy  <= 1'b0;
              drain_cnt <= drain_load;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - dw'(1);
          if (drain_cnt == dw'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Lanes take the live word only on fire; otherwise (DRAIN, stalls) they see zeros.
  for (genvar i = 0; i < size; i++) begin : g_lane
    logic [n-1:0] x_d;
    logic [n-1:0] w_d;

    assign x_d = fire ? recv_x[i*n +: n] : '0;
    assign w_d = fire ? recv_w[i*n +: n] : '0;

    systolic_skew_lane #(.n(n), .depth(i)) u_x_lane (
      .clk (clk),
      .rst (rst),
      .en  (en_out),
      .d   (x_d),
      .q   (x_out[i*n +: n])
    );

    systolic_skew_lane #(.n(n), .depth(i)) u_w_lane (
      .clk (clk),
      .rst (rst),
      .en  (en_out),
      .d   (w_d),
      .q   (w_out[i*n +: n])
    );
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stalls <= '0;
    end else if (state == IDLE && start) begin
      perf_stalls <= '0;
    end else if (state == STREAM && !recv_val && perf_stalls != '1) begin
      perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed self-checking bench for systolic_feeder (size=4, n=16, lw=8).
module tb_systolic_feeder;

  localparam int n    = 16;
  localparam int size = 4;
  localparam int lw   = 8;

  logic              clk;
  logic              rst;
  logic              start;
  logic [lw-1:0]     len;
  logic [size*n-1:0] recv_x;
  logic [size*n-1:0] recv_w;
  logic              recv_val;
  logic              recv_rdy;
  logic [size*n-1:0] x_out;
  logic [size*n-1:0] w_out;
  logic              en_out;
  logic              busy;
  logic              done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [31:0]       perf_stalls;
`endif

  int checks   = 0;
  int failures = 0;

  systolic_feeder #(.n(n), .size(size), .lw(lw)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .recv_x   (recv_x),
    .recv_w   (recv_w),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .x_out    (x_out),
    .w_out    (w_out),
    .en_out   (en_out),
    .busy     (busy),
    .done     (done)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    ,
    .perf_stalls (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected skewed outputs for x={4,3,2,1}, w={8,7,6,5}, cycles after fire.
  localparam logic [63:0] exp_skew_x [9] = '{
    64'h0000_0000_0000_0001, 64'h0000_0000_0002_0000,
    64'h0000_0003_0000_0000, 64'h0004_0000_0000_0000,
    64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
  localparam logic [63:0] exp_skew_w [9] = '{
    64'h0000_0000_0000_0005, 64'h0000_0000_0006_0000,
    64'h0000_0007_0000_0000, 64'h0008_0000_0000_0000,
    64'h0, 64'h0, 64'h0, 64'h0, 64'h0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string p, input int budget, output int cycles);
    cycles = 0;
    for (int c = 1; c <= budget; c++) begin
      tick();
      #4;
      if (done) begin
        cycles = c;
        break;
      end
    end
    if (cycles == 0) check({p, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_skew(input string p);
    int en_cnt;
    int done_cnt;
    en_cnt   = 0;
    done_cnt = 0;
    tick(); start = 1'b1; len = 8'd1; #4;
    check({p, "_idle_busy"}, busy, 1'b0);
    tick(); start = 1'b0; recv_val = 1'b1;
    recv_x = {16'd4, 16'd3, 16'd2, 16'd1};
    recv_w = {16'd8, 16'd7, 16'd6, 16'd5};
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin
        tick();
        recv_x = '1;
        recv_w = '1;
      end
      #4;
      check($sformatf("%s_x_c%0d", p, c), x_out, exp_skew_x[c]);
      check($sformatf("%s_w_c%0d", p, c), w_out, exp_skew_w[c]);
      if (en_out) en_cnt++;
      if (done) begin
        done_cnt++;
        check({p, "_done_cycle"}, 64'(c), 64'd7);
      end
    end
    check({p, "_en_cycles"}, 64'(en_cnt), 64'd7);
    check({p, "_done_count"}, 64'(done_cnt), 64'd1);
    recv_val = 1'b0;
    recv_x   = '0;
    recv_w   = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    int drain_cnt;
    int done_cnt;
    int cyc;

    rst = 1'b1; start = 1'b0; len = '0; recv_val = 1'b0; recv_x = '0; recv_w = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset / idle
    for (int c = 0; c < 5; c++) begin
      tick(); #4;
      check("idle_rdy", recv_rdy, 1'b0);
      check("idle_en", en_out, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_done", done, 1'b0);
      check("idle_x", x_out, 64'h0);
      check("idle_w", w_out, 64'h0);
    end

    run_skew("skew");

    // Back-to-back, len=3; vector c lane i = c*256+i
    tick(); start = 1'b1; len = 8'd3; #4;
    tick(); start = 1'b0; recv_val = 1'b1;
    busy_cnt = 0; drain_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) tick();
      for (int i = 0; i < size; i++) recv_x[i*n +: n] = (c < 3) ? 16'(c * 256 + i) : 16'hffff;
      #4;
      if (busy) busy_cnt++;
      if (busy && !recv_rdy && en_out) drain_cnt++;
      if (done) begin
        done_cnt++;
        check("b2b_done_cycle", 64'(c), 64'd9);
      end
      if (c == 2) begin
        check("b2b_rdy_c2", recv_rdy, 1'b1);
        check("b2b_x_c2", x_out, 64'h0000_0002_0101_0200);
      end
      if (c == 3) check("b2b_rdy_c3", recv_rdy, 1'b0);
    end
    check("b2b_busy_cycles", 64'(busy_cnt), 64'd9);
    check("b2b_drain_cycles", 64'(drain_cnt), 64'd6);
    check("b2b_done_count", 64'(done_cnt), 64'd1);
    recv_val = 1'b0; recv_x = '0;

    // Stall: len=2 with 3 idle cycles between vectors
    tick(); start = 1'b1; len = 8'd2; #4;
    tick(); start = 1'b0; recv_val = 1'b1;
    recv_x = {16'h13, 16'h12, 16'h11, 16'h10}; #4;
    check("stall_fire0_en", en_out, 1'b1);
    for (int g = 0; g < 3; g++) begin
      tick(); recv_val = 1'b0; recv_x = '1; #4;
      check("stall_gap_en", en_out, 1'b0);
      check("stall_gap_rdy", recv_rdy, 1'b1);
      check("stall_gap_x", x_out, 64'h0000_0000_0011_0000);
    end
    tick(); recv_val = 1'b1; recv_x = {16'h23, 16'h22, 16'h21, 16'h20}; #4;
    check("stall_fire1_en", en_out, 1'b1);
    check("stall_fire1_x", x_out, 64'h0000_0000_0011_0020);
    tick(); recv_val = 1'b0; recv_x = '0; #4;
    check("stall_drain_rdy", recv_rdy, 1'b0);
    check("stall_drain_x", x_out, 64'h0000_0012_0021_0000);
    wait_done("stall", 12, cyc);
    check("stall_done_delay", 64'(cyc), 64'd6);
`ifdef SYSTOLIC_FEEDER_PERF_EN
    check("stall_perf", 64'(perf_stalls), 64'd3);
`endif

    // len=0 start
    tick(); start = 1'b1; len = 8'd0; #4;
    check("len0_busy", busy, 1'b0);
    tick(); start = 1'b0; #4;
    check("len0_done", done, 1'b1);
    check("len0_en", en_out, 1'b0);
    check("len0_busy2", busy, 1'b0);
    tick(); #4;
    check("len0_done_clear", done, 1'b0);
    check("len0_rdy", recv_rdy, 1'b0);

    // Second start during STREAM is ignored
    tick(); start = 1'b1; len = 8'd1; #4;
    tick(); start = 1'b1; len = 8'd5; recv_val = 1'b0; #4;
    check("restart_rdy", recv_rdy, 1'b1);
    tick(); start = 1'b0; recv_val = 1'b1; recv_x = {16'd0, 16'd0, 16'd0, 16'h55}; #4;
    check("restart_fire_en", en_out, 1'b1);
    check("restart_fire_x", x_out, 64'h55);
    tick(); recv_val = 1'b0; recv_x = '0; #4;
    check("restart_drain_rdy", recv_rdy, 1'b0);
    check("restart_drain_busy", busy, 1'b1);
    wait_done("restart", 12, cyc);
    check("restart_done_delay", 64'(cyc), 64'd6);

    // Asynchronous reset mid-DRAIN
    tick(); start = 1'b1; len = 8'd1; #4;
    tick(); start = 1'b0; recv_val = 1'b1;
    recv_x = {16'd4, 16'd3, 16'd2, 16'd1};
    recv_w = {16'd8, 16'd7, 16'd6, 16'd5}; #4;
    tick(); recv_val = 1'b0; recv_x = '0; recv_w = '0; #4;
    tick(); #4;
    check("abort_pre_x", x_out, 64'h0000_0003_0000_0000);
    #1 rst = 1'b1;
    #1;
    check("abort_x", x_out, 64'h0);
    check("abort_w", w_out, 64'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_en", en_out, 1'b0);
    check("abort_rdy", recv_rdy, 1'b0);
    done_cnt = 0;
    repeat (2) begin
      tick(); #4;
      if (done) done_cnt++;
    end
    tick(); rst = 1'b0; #4;
    if (done) done_cnt++;
    repeat (10) begin
      tick(); #4;
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);

    run_skew("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
